// File: rtl/cdc_pkg.sv
// Shared types and constants for the four-phase req/ack clock-domain handshake.
package cdc_pkg;
  localparam int CDC_SYNC_STAGES_DEF = 2;
  localparam int CDC_XFER_CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } cdc_hs_state_t;
endpackage

// File: rtl/cdc_sync_bit.sv
// N-flop single-bit level synchronizer with asynchronous reset.
module cdc_sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  (* async_reg = "true" *) logic [N-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];
endmodule

// File: rtl/cdc_hs_rx.sv
// Destination-side four-phase handshake receiver: syncs req, captures the
// source-held word, hands it downstream with valid/ready and returns a flopped ack.
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_async,
  input  logic [WIDTH-1:0]          data_async,
  output logic                      ack,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CDC_XFER_CNT_W-1:0] xfer_cnt,
  output logic                      proto_err
);
  logic                      req_s;
  cdc_hs_state_t             state_q;
  logic                      ack_q, valid_q, perr_q;
  logic [WIDTH-1:0]          data_q;
  logic [CDC_XFER_CNT_W-1:0] cnt_q, cnt_d;

  cdc_sync_bit #(.N(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (req_async),
    .q_o (req_s)
  );

  assign cnt_d = cnt_q + 1'b1;

  // data_async is only sampled in IDLE on req_s high; the source holds it
  // stable until it sees ack, so no synchronizer is needed on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s) begin
            data_q  <= data_async;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (!req_s) perr_q <= 1'b1;
          if (out_ready) begin
            valid_q <= 1'b0;
            ack_q   <= 1'b1;
            cnt_q   <= cnt_d;
            state_q <= ACK;
          end
        end
        ACK: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign xfer_cnt  = cnt_q;
  assign proto_err = perr_q;
endmodule

// File: tb/tb_cdc_hs_rx.sv
// Scoreboarded bench for cdc_hs_rx: a source model drives the handshake and
// queues expected words; a monitor pops them on each downstream acceptance.
module tb_cdc_hs_rx;
  localparam int W  = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_async = 1'b0;
  logic [W-1:0]  data_async = '0;
  logic          ack;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   xfer_cnt;
  logic          proto_err;

  cdc_hs_rx #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_async  (req_async),
    .data_async (data_async),
    .ack        (ack),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_cnt   (xfer_cnt),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0] exp_cnt = '0;
  bit          prev_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: every accepted word must be the oldest outstanding request, and
  // the counter must have advanced by exactly one on the accepting edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) prev_acc = 0;
      else begin
        if (prev_acc) begin
          exp_cnt++;
          chk("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
        end
        prev_acc = 0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
          else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
          prev_acc = 1;
        end
      end
    end
  end

  task automatic raise(input logic [W-1:0] d);
    data_async = d;
    req_async  = 1'b1;
    exp_q.push_back(d);
  endtask

  task automatic wait_ack(input logic lvl, input int rdy_pct, output int n);
    n = 0;
    while (ack !== lvl && n < 300) begin
      if (rdy_pct >= 0) out_ready = ($urandom_range(99) < rdy_pct);
      tick();
      n++;
    end
    if (ack !== lvl) chk("ack_timeout", 32'(ack), 32'(lvl));
  endtask

  // One full four-phase transfer from the source's point of view.
  task automatic send(input logic [W-1:0] d, input int rdy_pct);
    int n;
    raise(d);
    wait_ack(1'b1, rdy_pct, n);
    req_async = 1'b0;
    wait_ack(1'b0, rdy_pct, n);
    data_async = W'($urandom);
  endtask

  initial begin
    int n;
    logic [W-1:0] d;

    #2;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_cnt", 32'(xfer_cnt), 0);
    chk("rst_perr", 32'(proto_err), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Basic transfer with latency checks.
    out_ready = 1'b1;
    raise(8'hA5);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("cap_latency", 32'(n), SS + 1);
    chk("cap_data", 32'(out_data), 32'hA5);
    tick();
    chk("ack_rise", 32'(ack), 1);
    chk("valid_one_cycle", 32'(out_valid), 0);
    req_async = 1'b0;
    n = 0;
    while (ack && n < 50) begin tick(); n++; end
    chk("rel_latency", 32'(n), SS + 1);
    chk("basic_cnt", 32'(xfer_cnt), 1);
    tick();

    // Backpressure: word and valid must hold, ack must stay low.
    out_ready = 1'b0;
    raise(8'h3C);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", {out_valid, ack, 22'd0, out_data}, {1'b1, 1'b0, 22'd0, 8'h3C});
    end
    out_ready = 1'b1;
    tick();
    chk("bp_ack", 32'(ack), 1);
    req_async = 1'b0;
    wait_ack(1'b0, -1, n);

    // Back-to-back: re-raise as soon as ack is seen low.
    for (int i = 1; i <= 4; i++) send(W'(i), 100);
    chk("b2b_cnt", 32'(xfer_cnt), 6);

    // Protocol violation: withdraw request while the word is held.
    out_ready = 1'b0;
    raise(8'h77);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    req_async = 1'b0;
    for (int i = 0; i < SS + 1; i++) tick();
    chk("perr_set", 32'(proto_err), 1);
    chk("perr_held", {out_valid, ack}, 2'b10);
    out_ready = 1'b1;
    tick();
    chk("perr_ack", 32'(ack), 1);
    tick();
    chk("perr_idle", 32'(ack), 0);
    tick(); tick();
    chk("perr_sticky", 32'(proto_err), 1);

    // Randomized transfers with random backpressure.
    for (int i = 0; i < 25; i++) send(W'($urandom), 30 + int'($urandom_range(70)));
    out_ready = 1'b1;

    // Counter wrap via preload.
    force dut.cnt_q = 16'hFFFF;
    #1 release dut.cnt_q;
    exp_cnt = 16'hFFFF;
    tick();
    send(8'hC3, 100);
    chk("cnt_wrap", 32'(xfer_cnt), 0);

    // Reset while in ACK with req still high: word is recaptured.
    d = 8'h5E;
    raise(d);
    wait_ack(1'b1, 100, n);
    rst = 1'b1;
    #1;
    chk("midrst_out", {ack, out_valid, proto_err, 5'd0, out_data, xfer_cnt}, 32'd0);
    exp_q.delete();
    exp_cnt = '0;
    exp_q.push_back(d);
    tick();
    rst = 1'b0;
    wait_ack(1'b1, 100, n);
    chk("recap_cnt", 32'(xfer_cnt), 1);
    req_async = 1'b0;
    wait_ack(1'b0, 100, n);

    for (int i = 0; i < 4; i++) tick();
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("final_perr", 32'(proto_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
